// File: rtl/ttl_nor_arbiter.sv
// ttl_nor_arbiter
//   Round-robin arbiter that time-shares one quad 2-input NOR package among
//   BLOCKS requesters. One owner at a time, ownership bounded to HOLD_MAX
//   cycles, and one dead (RELEASE) cycle between owners so the operand buses
//   in front of the shared package never overlap.
//
// Ports
//   Clk          in   single clock, rising edge
//   Clear        in   synchronous active-high reset, beats every other event
//   Req          in   [BLOCKS]  per-requester request level
//   Grant        out  [BLOCKS]  one-hot grant, zero when no owner
//   Grant_Index  out  [IW]      binary owner index (operand mux select), 0 idle
//   Busy         out  high while a grant is active (OR of Grant)
//   Timeout      out  one-cycle pulse after a grant revoked at HOLD_MAX
//
// All outputs are registered; there is no combinational Req->output path.
// DELAY_RISE/DELAY_FALL describe the package propagation delay for
// timing-annotated flows only; cycle behaviour does not depend on them.
module ttl_nor_arbiter #(
    parameter int BLOCKS     = 4,
    parameter int HOLD_MAX   = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0,
    localparam int IW = $clog2(BLOCKS),
    localparam int CW = $clog2(HOLD_MAX + 1)
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic [BLOCKS-1:0] Req,
    output logic [BLOCKS-1:0] Grant,
    output logic [IW-1:0]     Grant_Index,
    output logic              Busy,
    output logic              Timeout
);

    // Elaboration-time sanity checks on the parameter set.
    if (BLOCKS < 2) begin : g_chk_blocks
        $error("ttl_nor_arbiter: BLOCKS must be at least 2");
    end
    if (HOLD_MAX < 1) begin : g_chk_hold
        $error("ttl_nor_arbiter: HOLD_MAX must be at least 1");
    end
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_chk_dly
        $error("ttl_nor_arbiter: output delays must be non-negative");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_owner;
    logic [CW-1:0]     r_count;
    logic [BLOCKS-1:0] r_grant;
    logic [IW-1:0]     r_gidx;
    logic              r_busy;
    logic              r_timeout;

    logic              w_found;
    logic [IW-1:0]     w_sel;
    logic [IW-1:0]     w_ptr_next;

    // Round-robin search starting at r_ptr. Walking the offsets from high to
    // low lets the smallest offset (closest to the pointer) win. The wrap is
    // done by subtraction so non-power-of-2 BLOCKS never produce an index
    // outside 0..BLOCKS-1.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int k = BLOCKS - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= BLOCKS) idx = idx - BLOCKS;
            if (Req[IW'(idx)]) begin
                w_found = 1'b1;
                w_sel   = IW'(idx);
            end
        end
    end

    // Pointer advances past the owner, explicit wrap for any BLOCKS.
    assign w_ptr_next = (r_owner == IW'(BLOCKS - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_count   <= '0;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_sel;
                        r_count <= CW'(1);
                        r_grant <= BLOCKS'(1) << w_sel;
                        r_gidx  <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!Req[r_owner] || r_count == CW'(HOLD_MAX)) begin
                        // Voluntary release takes priority over the timeout.
                        r_timeout <= Req[r_owner];
                        r_grant   <= '0;
                        r_gidx    <= '0;
                        r_busy    <= 1'b0;
                        r_ptr     <= w_ptr_next;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_gidx  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Grant       = r_grant;
    assign Grant_Index = r_gidx;
    assign Busy        = r_busy;
    assign Timeout     = r_timeout;

endmodule

// File: tb/tb_ttl_nor_arbiter.sv
module tb_ttl_nor_arbiter;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] req;
    logic [2:0] req3;

    logic [3:0] grant;
    logic [1:0] gidx;
    logic       busy, tmo;
    logic [2:0] grant3;
    logic [1:0] gidx3;
    logic       busy3, tmo3;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ttl_nor_arbiter #(.BLOCKS(4), .HOLD_MAX(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk(clk), .Clear(clear), .Req(req),
        .Grant(grant), .Grant_Index(gidx), .Busy(busy), .Timeout(tmo)
    );

    ttl_nor_arbiter #(.BLOCKS(3), .HOLD_MAX(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut3 (
        .Clk(clk), .Clear(clear), .Req(req3),
        .Grant(grant3), .Grant_Index(gidx3), .Busy(busy3), .Timeout(tmo3)
    );

    // Expected grant episodes: owner index, grant length, timeout pulse after
    // the grant, idle cycles before it (-1 = not checked).
    typedef struct {
        int idx;
        int len;
        bit to;
        int gap;
    } exp_t;
    exp_t q[$];

    function automatic void push(int i, int l, bit t, int g);
        exp_t e;
        e.idx = i; e.len = l; e.to = t; e.gap = g;
        q.push_back(e);
    endfunction

    task automatic check(string name, int act, int req_v);
        tests++;
        if (act != req_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req_v, $time);
        end
    endtask

    // Scoreboard monitor for the 4-requester instance.
    bit   in_grant = 1'b0;
    int   cur_idx, len, gap;
    exp_t e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_eq_or_grant", int'(busy), int'(|grant));
            if (grant != 4'd0) begin
                check("grant_onehot_idx", int'(grant), int'(4'd1 << gidx));
                check("timeout_during_grant", int'(tmo), 0);
                if (!in_grant) begin
                    in_grant = 1'b1;
                    cur_idx  = int'(gidx);
                    len      = 0;
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_grant: got index %0d expected none at %0t", gidx, $time);
                    end else begin
                        check("grant_index", int'(gidx), q[0].idx);
                        if (q[0].gap >= 0) check("grant_gap", gap, q[0].gap);
                    end
                end
                check("owner_stable", int'(gidx), cur_idx);
                len++;
            end else begin
                check("idx_zero_idle", int'(gidx), 0);
                if (in_grant) begin
                    in_grant = 1'b0;
                    gap      = 1;
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("grant_length", len, e.len);
                        check("timeout_pulse", int'(tmo), int'(e.to));
                    end
                end else begin
                    gap++;
                    check("timeout_spurious", int'(tmo), 0);
                end
            end
        end
    end

    // Invariants for the 3-requester instance.
    always @(negedge clk) begin
        if (mon_en && grant3 != 3'd0) begin
            check("b3_idx_range", int'(gidx3 <= 2'd2), 1);
            check("b3_onehot_idx", int'(grant3), int'(3'd1 << gidx3));
            check("b3_busy", int'(busy3), 1);
        end
    end

    task automatic wait_grant(input bit sel3, output int idx);
        int n = 0;
        while (((sel3 ? grant3 != 3'd0 : grant != 4'd0) == 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if ((sel3 ? grant3 != 3'd0 : grant != 4'd0) == 1'b0) begin
            tests++;
            fails++;
            $display("FAIL wait_grant: got no grant expected one within 60 cycles at %0t", $time);
        end
        idx = sel3 ? int'(gidx3) : int'(gidx);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (grant != 4'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (grant != 4'd0) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: grant %b still high expected 0 at %0t", grant, $time);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int idx;
        int order3 [4] = '{0, 1, 2, 0};
        clear = 1'b1;
        req   = 4'd0;
        req3  = 3'd0;
        repeat (2) @(negedge clk);
        check("reset_grant", int'(grant), 0);
        check("reset_index", int'(gidx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_timeout", int'(tmo), 0);
        check("reset_grant3", int'(grant3), 0);
        clear  = 1'b0;
        gap    = 0;
        mon_en = 1'b1;

        // Single requester, Req held 3 cycles.
        do_clear();
        push(0, 3, 1'b0, -1);
        req = 4'b0001;
        @(negedge clk);
        check("latency_grant", int'(grant), 1);
        check("latency_busy", int'(busy), 1);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        // Round-robin fairness, each owner releases after 2 grant cycles.
        do_clear();
        push(0, 2, 1'b0, -1);
        push(1, 2, 1'b0, 2);
        push(2, 2, 1'b0, 2);
        push(3, 2, 1'b0, 2);
        push(0, 2, 1'b0, 2);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(1'b0, idx);
            @(negedge clk);
            if (g == 4) req = 4'b0000;
            else        req[idx] = 1'b0;
            @(negedge clk);
            if (g != 4) req[idx] = 1'b1;
        end
        repeat (4) @(negedge clk);

        // Hold limit with a single requester held 20 cycles.
        do_clear();
        push(2, 8, 1'b1, -1);
        push(2, 8, 1'b1, 2);
        req = 4'b0100;
        repeat (20) @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        // Timeout fairness between two persistent requesters.
        do_clear();
        push(0, 8, 1'b1, -1);
        push(1, 8, 1'b1, 2);
        push(0, 8, 1'b1, 2);
        req = 4'b0011;
        repeat (3) begin
            wait_grant(1'b0, idx);
            wait_idle();
        end
        req = 4'b0000;
        repeat (4) @(negedge clk);

        // Clear during the 4th grant cycle of index 3, then re-grant to 3.
        do_clear();
        push(3, 4, 1'b0, -1);
        push(3, 8, 1'b1, -1);
        req = 4'b1000;
        wait_grant(1'b0, idx);
        check("clr_owner", idx, 3);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check("clr_grant", int'(grant), 0);
        check("clr_index", int'(gidx), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_timeout", int'(tmo), 0);
        clear = 1'b0;
        wait_grant(1'b0, idx);
        wait_idle();
        req = 4'b0000;
        repeat (4) @(negedge clk);

        // Non-power-of-2 wrap on the 3-requester instance.
        do_clear();
        req3 = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_grant(1'b1, idx);
            check("b3_order", idx, order3[g]);
            if (g == 3) req3 = 3'b000;
            else        req3[idx] = 1'b0;
            @(negedge clk);
            check("b3_release", int'(grant3), 0);
            if (g != 3) req3[idx] = 1'b1;
        end
        repeat (4) @(negedge clk);
        check("b3_idle_after", int'(grant3), 0);

        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
